// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared CPU-side types: the 32-bit word and the RAM status
//                code reported by the memory model to its requester.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

    // Native datapath word.
    typedef logic [31:0] word_t;

    // RAM status as seen by the arbiter.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates one single-ported RAM between an instruction
//                requester and a data requester. Ownership is granted from
//                IDLE with round-robin on ties; completion is signalled
//                combinationally in the cycle the RAM reports ACCESS. RAM
//                ERROR or a wait-counter timeout ends the access with a zero
//                load and sets the sticky memerr flag.
//  Revision    : 1.0 - initial release
//
//  Ports
//    CLK                 in   clock, rising edge
//    RST                 in   synchronous active-high reset
//    iREN, iaddr         in   instruction read request / word address
//    iload, iwait        out  instruction read data / stall
//    dREN, dWEN          in   data read / write requests
//    daddr, dstore       in   data address / write data
//    dload, dwait        out  data read data / stall
//    ramREN, ramWEN      out  RAM read / write strobes
//    ramaddr, ramstore   out  RAM address / write data
//    ramload             in   RAM read data
//    ramstate            in   RAM status (FREE, BUSY, ACCESS, ERROR)
//    memerr              out  sticky error/timeout flag, cleared by RST only
// ============================================================================
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    output word_t     iload,
    output logic      iwait,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output word_t     dload,
    output logic      dwait,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate,
    output logic      memerr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IACC = 2'd1,
        ST_DACC = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    // Counter value on the last cycle an access may wait.
    localparam logic [7:0] c_timeout_last = 8'(TIMEOUT - 1);

    state_t      r_state;
    grant_t      r_lastgrant;
    logic [7:0]  r_count;
    logic        r_memerr;

    logic        w_dreq;
    logic        w_owner_req;
    logic        w_hit;
    logic        w_fault;
    logic        w_expired;
    logic        w_done;

    assign w_dreq    = dREN | dWEN;
    assign w_hit     = (ramstate == ACCESS);
    assign w_fault   = (ramstate == ERROR);
    assign w_expired = (r_count == c_timeout_last);

    // The owner must still be requesting; a dropped request abandons the
    // access even if the RAM happens to answer in that same cycle.
    assign w_owner_req = (r_state == ST_IACC) ? iREN :
                         (r_state == ST_DACC) ? w_dreq : 1'b0;

    assign w_done = w_owner_req & (w_hit | w_fault | w_expired);

    assign memerr = r_memerr;

    // Output mux. RST gates everything so an access being aborted by reset
    // can never flash a completion in the reset cycle.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        if (!RST) begin
            case (r_state)
                ST_IACC: begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (w_done) begin
                        iwait = 1'b0;
                        iload = w_hit ? ramload : '0;
                    end
                end
                ST_DACC: begin
                    // A write takes precedence over a simultaneous read.
                    ramWEN   = dWEN;
                    ramREN   = dREN & ~dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                    if (w_done) begin
                        dwait = 1'b0;
                        dload = w_hit ? ramload : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Grant FSM, wait counter and sticky error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_lastgrant <= GRANT_INSTR;
            r_count     <= '0;
            r_memerr    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Data goes first unless it was the last one served and
                    // instruction is also waiting.
                    if (w_dreq && (r_lastgrant == GRANT_INSTR || !iREN)) begin
                        r_state     <= ST_DACC;
                        r_lastgrant <= GRANT_DATA;
                        r_count     <= '0;
                    end else if (iREN) begin
                        r_state     <= ST_IACC;
                        r_lastgrant <= GRANT_INSTR;
                        r_count     <= '0;
                    end
                end
                ST_IACC, ST_DACC: begin
                    if (!w_owner_req || w_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                    // Any completion without real data is an error.
                    if (w_done && !w_hit) begin
                        r_memerr <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
